// File: rtl/pipeline_mem.sv
// Memory-access pipeline stage: turns execute results into data-memory
// load/store transactions and hands a registered writeback bundle downstream.
module pipeline_mem #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  ready,
  input  logic [DATA_WIDTH-1:0] ex_res,
  input  logic [DATA_WIDTH-1:0] r2_val_mem,
  input  logic [4:0]            mem_dst_reg,
  input  logic [31:0]           next_mem_opcode,
  input  logic [2:0]            next_mem_operation_size,
  input  logic                  ecall_mem,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [7:0]            dmem_wstrb,
  input  logic                  dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [4:0]            wb_dst_reg,
  output logic                  wb_we,
  output logic                  wb_ecall,
  output logic                  wb_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                state_q, state_d;
  logic [2:0]            off_in;
  logic [7:0]            lane_mask;
  logic                  is_load, is_store, misaligned;
  logic                  accept, mem_accept, pass_accept;
  logic                  store_done, load_hs, load_done;
  logic [2:0]            off_q;
  logic [2:0]            size_q;
  logic [4:0]            dst_q;
  logic                  ecall_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] load_ext;

  assign off_in   = ex_res[2:0];
  assign is_load  = (next_mem_opcode == 32'd1);
  assign is_store = (next_mem_opcode == 32'd2);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    lane_mask  = 8'h01;
    misaligned = 1'b0;
    case (next_mem_operation_size[1:0])
      2'd0: begin lane_mask = 8'h01; misaligned = 1'b0;         end
      2'd1: begin lane_mask = 8'h03; misaligned = off_in[0];    end
      2'd2: begin lane_mask = 8'h0F; misaligned = |off_in[1:0]; end
      2'd3: begin lane_mask = 8'hFF; misaligned = |off_in;      end
      default: ;
    endcase
  end

  assign ready       = (state_q == IDLE) && (!wb_valid || wb_ready);
  assign accept      = in_valid && ready;
  assign mem_accept  = accept && (is_load || is_store) && !misaligned;
  assign pass_accept = accept && !mem_accept;
  assign store_done  = (state_q == REQ) && dmem_req_ready && dmem_we;
  assign load_hs     = (state_q == REQ) && dmem_req_ready && !dmem_we;
  assign load_done   = (state_q == WAIT) && dmem_resp_valid;
  assign dmem_req_valid = (state_q == REQ);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_accept) state_d = REQ;
      REQ:     if (store_done) state_d = IDLE;
               else if (load_hs) state_d = WAIT;
      WAIT:    if (load_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The captured offset/size select and extend the returned lane.
  always_comb begin
    sh       = dmem_rdata >> {off_q, 3'b000};
    load_ext = sh;
    case (size_q[1:0])
      2'd0: load_ext = size_q[2] ? {{(DATA_WIDTH-8){1'b0}}, sh[7:0]}
                                 : {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      2'd1: load_ext = size_q[2] ? {{(DATA_WIDTH-16){1'b0}}, sh[15:0]}
                                 : {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      2'd2: load_ext = size_q[2] ? {{(DATA_WIDTH-32){1'b0}}, sh[31:0]}
                                 : {{(DATA_WIDTH-32){sh[31]}}, sh[31:0]};
      default: load_ext = sh;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: all state here is plain flops, so each one is cleared by the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      off_q      <= '0;
      size_q     <= '0;
      dst_q      <= '0;
      ecall_q    <= 1'b0;
      res_q      <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_dst_reg <= '0;
      wb_we      <= 1'b0;
      wb_ecall   <= 1'b0;
      wb_fault   <= 1'b0;
    end else begin
      if (accept) begin
        off_q   <= off_in;
        size_q  <= next_mem_operation_size;
        dst_q   <= mem_dst_reg;
        ecall_q <= ecall_mem;
        res_q   <= ex_res;
      end
      // Request fields load once and stay put until the handshake.
      if (mem_accept) begin
        dmem_we    <= is_store;
        dmem_addr  <= {ex_res[ADDR_WIDTH-1:3], 3'b000};
        dmem_wdata <= r2_val_mem << {off_in, 3'b000};
        dmem_wstrb <= lane_mask << off_in;
      end
      if (pass_accept) begin
        wb_valid   <= 1'b1;
        wb_data    <= ex_res;
        wb_dst_reg <= mem_dst_reg;
        wb_we      <= !misaligned && (mem_dst_reg != 5'd0);
        wb_ecall   <= ecall_mem;
        wb_fault   <= misaligned && (is_load || is_store);
      end else if (store_done || load_done) begin
        wb_valid   <= 1'b1;
        wb_data    <= load_done ? load_ext : res_q;
        wb_dst_reg <= dst_q;
        wb_we      <= load_done && (dst_q != 5'd0);
        wb_ecall   <= ecall_q;
        wb_fault   <= 1'b0;
      end else if (wb_valid && wb_ready) begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_mem.sv
// Bench for pipeline_mem: directed cases plus randomized transactions checked
// against a byte-lane reference model of loads, stores and passthrough.
module tb_pipeline_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        ready;
  logic [63:0] ex_res, r2_val_mem;
  logic [4:0]  mem_dst_reg;
  logic [31:0] next_mem_opcode;
  logic [2:0]  next_mem_operation_size;
  logic        ecall_mem;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_resp_valid;
  logic [63:0] dmem_rdata;
  logic        wb_valid, wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_dst_reg;
  logic        wb_we, wb_ecall, wb_fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_mem #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ready(ready),
    .ex_res(ex_res), .r2_val_mem(r2_val_mem), .mem_dst_reg(mem_dst_reg),
    .next_mem_opcode(next_mem_opcode), .next_mem_operation_size(next_mem_operation_size),
    .ecall_mem(ecall_mem), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_data(wb_data), .wb_dst_reg(wb_dst_reg), .wb_we(wb_we),
    .wb_ecall(wb_ecall), .wb_fault(wb_fault)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-by-byte view of the memory bus.
  function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [2:0] off,
                                             input logic [2:0] sz);
    int n = 1 << sz[1:0];
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!sz[2] && n < 8 && v[8*n-1])
      for (int j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] r2, input logic [2:0] off);
    logic [63:0] v = '0;
    for (int l = 0; l < 8; l++) if (l >= off) v[8*l +: 8] = r2[8*(l-off) +: 8];
    return v;
  endfunction

  function automatic logic [7:0] model_wstrb(input logic [2:0] off, input logic [2:0] sz);
    int n = 1 << sz[1:0];
    logic [7:0] s = '0;
    for (int l = 0; l < 8; l++) if (l >= off && l < off + n) s[l] = 1'b1;
    return s;
  endfunction

  task automatic run_op(input logic [31:0] opc, input logic [2:0] sz, input logic [63:0] res,
                        input logic [63:0] r2, input logic [4:0] dst, input logic ec,
                        input int req_wait, input int resp_wait, input logic [63:0] rdata);
    logic [2:0] off = res[2:0];
    int n = 1 << sz[1:0];
    bit mis = (off % n) != 0;
    bit ld = (opc == 32'd1);
    bit st = (opc == 32'd2);
    bit mem_op = (ld || st) && !mis;
    @(negedge clk);
    in_valid = 1'b1; next_mem_opcode = opc; next_mem_operation_size = sz;
    ex_res = res; r2_val_mem = r2; mem_dst_reg = dst; ecall_mem = ec;
    #1 check("ready_idle", ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (!mem_op) begin
      check("pass_valid", wb_valid, 1);
      check("pass_data", wb_data, res);
      check("pass_we", wb_we, (!mis && dst != 0));
      check("pass_fault", wb_fault, mis && (ld || st));
      check("pass_ecall", wb_ecall, ec);
      check("pass_dst", wb_dst_reg, dst);
      check("pass_noreq", dmem_req_valid, 0);
    end else begin
      for (int c = 0; c <= req_wait; c++) begin
        check("req_valid", dmem_req_valid, 1);
        check("req_addr", dmem_addr, {res[63:3], 3'b000});
        check("req_we", dmem_we, st);
        if (st) begin
          check("req_wdata", dmem_wdata, model_wdata(r2, off));
          check("req_wstrb", dmem_wstrb, model_wstrb(off, sz));
        end
        check("req_ready_out", ready, 0);
        check("req_wb_idle", wb_valid, 0);
        if (c == req_wait) dmem_req_ready = 1'b1;
        @(negedge clk);
      end
      dmem_req_ready = 1'b0;
      if (st) begin
        check("st_wb_valid", wb_valid, 1);
        check("st_wb_we", wb_we, 0);
        check("st_wb_fault", wb_fault, 0);
        check("st_wb_ecall", wb_ecall, ec);
        check("st_req_drop", dmem_req_valid, 0);
      end else begin
        for (int c = 0; c < resp_wait; c++) begin
          check("wait_wb_idle", wb_valid, 0);
          check("wait_ready", ready, 0);
          check("wait_noreq", dmem_req_valid, 0);
          @(negedge clk);
        end
        dmem_resp_valid = 1'b1; dmem_rdata = rdata;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        check("ld_wb_valid", wb_valid, 1);
        check("ld_wb_data", wb_data, model_load(rdata, off, sz));
        check("ld_wb_we", wb_we, dst != 0);
        check("ld_wb_fault", wb_fault, 0);
        check("ld_wb_dst", wb_dst_reg, dst);
        check("ld_wb_ecall", wb_ecall, ec);
      end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; ex_res = '0; r2_val_mem = '0; mem_dst_reg = '0;
    next_mem_opcode = '0; next_mem_operation_size = '0; ecall_mem = 1'b0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = '0; wb_ready = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_req_valid", dmem_req_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wstrb", dmem_wstrb, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_ready", ready, 1);
    reset = 1'b1;

    // Stray response in IDLE is ignored
    @(negedge clk);
    dmem_resp_valid = 1'b1; dmem_rdata = 64'h1111;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    check("idle_resp_ignored", wb_valid, 0);

    // ALU passthrough
    run_op(32'd0, 3'd3, 64'h1234, 64'h0, 5'd5, 1'b0, 0, 0, 64'h0);
    run_op(32'd0, 3'd3, 64'h1234, 64'h0, 5'd0, 1'b0, 0, 0, 64'h0);

    // Signed/unsigned byte load, minimum latency
    run_op(32'd1, 3'd0, 64'h1003, 64'h0, 5'd3, 1'b0, 0, 0, 64'h00000000_80000000);
    check("sbyte_const", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    run_op(32'd1, 3'd4, 64'h1003, 64'h0, 5'd3, 1'b0, 0, 0, 64'h00000000_80000000);
    check("ubyte_const", wb_data, 64'h80);

    // Store word with request backpressure
    run_op(32'd2, 3'd2, 64'h2004, 64'hDEADBEEF, 5'd4, 1'b0, 3, 0, 64'h0);
    check("sw_wdata_const", dmem_wdata, 64'hDEADBEEF_00000000);
    check("sw_wstrb_const", dmem_wstrb, 8'hF0);

    // Misaligned half load
    run_op(32'd1, 3'd1, 64'h3001, 64'h0, 5'd6, 1'b0, 0, 0, 64'h0);

    // Ecall on a store does not change the transaction
    run_op(32'd2, 3'd3, 64'h5008, 64'hCAFE, 5'd1, 1'b1, 1, 0, 64'h0);

    // Output backpressure, then back-to-back acceptance when wb_ready rises
    @(negedge clk);
    wb_ready = 1'b0;
    in_valid = 1'b1; next_mem_opcode = 32'd0; ex_res = 64'hAAAA; mem_dst_reg = 5'd7; ecall_mem = 1'b0;
    @(negedge clk);
    ex_res = 64'hBBBB; mem_dst_reg = 5'd9;
    for (int c = 0; c < 4; c++) begin
      check("bp_ready", ready, 0);
      check("bp_valid", wb_valid, 1);
      check("bp_data", wb_data, 64'hAAAA);
      check("bp_dst", wb_dst_reg, 5'd7);
      @(negedge clk);
    end
    wb_ready = 1'b1;
    #1 check("bp_ready_rise", ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_valid", wb_valid, 1);
    check("b2b_data", wb_data, 64'hBBBB);
    check("b2b_dst", wb_dst_reg, 5'd9);
    @(negedge clk);
    check("b2b_drain", wb_valid, 0);

    // Randomized transactions
    for (int k = 0; k < 60; k++) begin
      logic [31:0] opc;
      case ($urandom_range(0, 3))
        0: opc = 32'd0;
        1: opc = 32'd1;
        2: opc = 32'd2;
        default: opc = $urandom | 32'd3;
      endcase
      run_op(opc, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             $urandom_range(0, 3), {$urandom, $urandom});
    end

    // Reset while waiting for a load response, then a late response
    @(negedge clk);
    dmem_req_ready = 1'b1;
    in_valid = 1'b1; next_mem_opcode = 32'd1; next_mem_operation_size = 3'd3;
    ex_res = 64'h4000; mem_dst_reg = 5'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("rw_req", dmem_req_valid, 1);
    @(negedge clk);
    dmem_req_ready = 1'b0;
    check("rw_in_wait", ready, 0);
    reset = 1'b0;
    #1;
    check("rw_req_valid", dmem_req_valid, 0);
    check("rw_addr", dmem_addr, 0);
    check("rw_wb_valid", wb_valid, 0);
    check("rw_wb_data", wb_data, 0);
    check("rw_wb_we", wb_we, 0);
    @(negedge clk);
    reset = 1'b1;
    dmem_resp_valid = 1'b1; dmem_rdata = 64'h7777;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    check("rw_late_ignored", wb_valid, 0);
    check("rw_ready", ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
